sweep_peak_analyzer: RTL and testbench
======================================

SWEEP_PEAK_ANALYZER -- requirements
Module: sweep_peak_analyzer

Interface
REQ-001 SHALL have parameter PHASE_STEP_WIDTH, default 32, width of phase-step values.
REQ-002 SHALL have parameter DATA_WIDTH, default 17, width of signed input sample and unsigned peak.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16, width of settle/dwell sample counts.
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle sweep request.
REQ-007 SHALL have port abort  input  1  terminate the sweep immediately.
REQ-008 SHALL have ports start_step, step_increment, stop_step  input  PHASE_STEP_WIDTH  sweep configuration.
REQ-009 SHALL have ports settle_samples, dwell_samples  input  COUNT_WIDTH  samples discarded / measured per step.
REQ-010 SHALL have port data  input  DATA_WIDTH  signed two's-complement filter output sample.
REQ-011 SHALL have port data_valid  input  1  data qualifier.
REQ-012 SHALL have port phase_step  output  PHASE_STEP_WIDTH  step driven to the tone generator.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have ports result_step (PHASE_STEP_WIDTH) and result_peak (DATA_WIDTH, unsigned)  output  measured point.
REQ-015 SHALL have ports result_valid  output  1 and result_ready  input  1  valid/ready result handshake.
REQ-016 SHALL have port done  output  1  one-cycle pulse at normal sweep completion.

Function
REQ-017 SHALL implement states IDLE, SETTLE, MEASURE, REPORT, DONE.
REQ-018 IDLE + start: latch all configuration inputs, phase_step <= start_step, sample counter <= 0, go SETTLE; start outside IDLE ignored.
REQ-019 SETTLE: count data_valid samples; once count equals latched settle_samples go MEASURE, so settle_samples=0 -> MEASURE on next cycle; peak <= 0 on entry to MEASURE.
REQ-020 MEASURE: per data_valid sample, peak <= max(peak, |data|); |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1) represented exactly, no saturation.
REQ-021 MEASURE ends after dwell_samples samples (dwell_samples=0 treated as 1); result_valid high the cycle after the final sample, result_peak including that sample, result_step = phase_step.
REQ-022 REPORT: result_valid, result_step, result_peak, phase_step held stable until result_valid && result_ready; data ignored.
REQ-023 On handshake: next = phase_step + step_increment computed at PHASE_STEP_WIDTH+1 bits; carry out, next > stop_step, or step_increment=0 -> DONE; else phase_step <= next, counter <= 0, go SETTLE.
REQ-024 start_step > stop_step SHALL yield exactly one measured point, then DONE.
REQ-025 DONE: done high one cycle, result_valid low, then IDLE; phase_step retains last value.
REQ-026 abort in any non-IDLE state: IDLE next cycle, result_valid low, no done pulse; abort wins over a same-cycle handshake (result discarded).
REQ-027 data_valid SHALL be ignored in IDLE, REPORT, DONE.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE and phase_step, busy, result_step, result_peak, result_valid, done, counters to 0.
REQ-029 Operation SHALL resume on the first rising edge after reset_n deasserts; no configuration retained.

Verification
REQ-030 start_step=0x000FFFFF, inc=0x00100000, stop=0x004FFFFF, settle=4, dwell=8, data=1000 valid every cycle, ready=1 -> 5 results steps 0x000FFFFF..0x004FFFFF, peak 1000 each, single done pulse, busy low after.
REQ-031 Dwell of 8 with data alternating 100, -65536 (0x10000), 200 -> result_peak 65536 (0x10000).
REQ-032 start_step=0xFFE00000, inc=0x00100000, stop=0xFFFFFFFF -> results at 0xFFE00000, 0xFFF00000 only; carry terminates, done pulses.
REQ-033 result_ready low 20 cycles during REPORT with data toggling -> result_valid held, result_step/result_peak/phase_step unchanged, next step only after handshake.
REQ-034 abort mid-MEASURE -> busy 0 next cycle, no done, no result; subsequent start runs full sweep normally.
REQ-035 reset_n pulsed low mid-REPORT (no clock edge) -> all outputs 0 immediately; start after release begins fresh sweep at start_step.

Source files
------------

// File: rtl/sweep_peak_analyzer.sv
// rtl/sweep_peak_analyzer.sv - frequency-sweep controller measuring peak |data| per phase step
module sweep_peak_analyzer #(
  parameter int PHASE_STEP_WIDTH = 32,
  parameter int DATA_WIDTH       = 17,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PHASE_STEP_WIDTH-1:0] start_step,
  input  logic [PHASE_STEP_WIDTH-1:0] step_increment,
  input  logic [PHASE_STEP_WIDTH-1:0] stop_step,
  input  logic [COUNT_WIDTH-1:0]      settle_samples,
  input  logic [COUNT_WIDTH-1:0]      dwell_samples,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        data_valid,
  output logic [PHASE_STEP_WIDTH-1:0] phase_step,
  output logic                        busy,
  output logic [PHASE_STEP_WIDTH-1:0] result_step,
  output logic [DATA_WIDTH-1:0]       result_peak,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_REPORT,
    S_DONE
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  DAT_ONE = DATA_WIDTH'(1);

  state_e                      state_q;
  logic [PHASE_STEP_WIDTH-1:0] phase_step_q;
  logic [PHASE_STEP_WIDTH-1:0] inc_q;
  logic [PHASE_STEP_WIDTH-1:0] stop_q;
  logic [PHASE_STEP_WIDTH-1:0] result_step_q;
  logic [COUNT_WIDTH-1:0]      settle_q;
  logic [COUNT_WIDTH-1:0]      dwell_q;
  logic [COUNT_WIDTH-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0]       peak_q;
  logic [DATA_WIDTH-1:0]       result_peak_q;
  logic                        result_valid_q;
  logic                        done_q;

  logic [DATA_WIDTH-1:0]       abs_d;
  logic [DATA_WIDTH-1:0]       peak_d;
  logic [COUNT_WIDTH-1:0]      cnt_d;
  logic                        last_sample_d;
  logic [PHASE_STEP_WIDTH:0]   next_step_d;
  logic                        sweep_end_d;

  always_comb begin
    // Unsigned magnitude: the most negative input maps to 2^(DATA_WIDTH-1) exactly.
    abs_d         = data[DATA_WIDTH-1] ? ((~data) + DAT_ONE) : data;
    peak_d        = (abs_d > peak_q) ? abs_d : peak_q;
    cnt_d         = cnt_q + CNT_ONE;
    // A dwell of zero behaves as one sample since cnt_d >= 0 always holds.
    last_sample_d = (cnt_d >= dwell_q);
    next_step_d   = {1'b0, phase_step_q} + {1'b0, inc_q};
    sweep_end_d   = next_step_d[PHASE_STEP_WIDTH]
                  || (next_step_d[PHASE_STEP_WIDTH-1:0] > stop_q)
                  || (inc_q == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      phase_step_q   <= '0;
      inc_q          <= '0;
      stop_q         <= '0;
      result_step_q  <= '0;
      settle_q       <= '0;
      dwell_q        <= '0;
      cnt_q          <= '0;
      peak_q         <= '0;
      result_peak_q  <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q        <= S_IDLE;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            inc_q        <= step_increment;
            stop_q       <= stop_step;
            settle_q     <= settle_samples;
            dwell_q      <= dwell_samples;
            phase_step_q <= start_step;
            cnt_q        <= '0;
            state_q      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == settle_q) begin
            cnt_q   <= '0;
            peak_q  <= '0;
            state_q <= S_MEASURE;
          end else if (data_valid) begin
            cnt_q <= cnt_d;
          end
        end
        S_MEASURE: begin
          if (data_valid) begin
            peak_q <= peak_d;
            cnt_q  <= cnt_d;
            if (last_sample_d) begin
              result_peak_q  <= peak_d;
              result_step_q  <= phase_step_q;
              result_valid_q <= 1'b1;
              state_q        <= S_REPORT;
            end
          end
        end
        S_REPORT: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            if (sweep_end_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              phase_step_q <= next_step_d[PHASE_STEP_WIDTH-1:0];
              cnt_q        <= '0;
              state_q      <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign phase_step   = phase_step_q;
  assign busy         = (state_q != S_IDLE);
  assign result_step  = result_step_q;
  assign result_peak  = result_peak_q;
  assign result_valid = result_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sweep_peak_analyzer.sv
// tb/tb_sweep_peak_analyzer.sv - directed self-checking bench for sweep_peak_analyzer
module tb_sweep_peak_analyzer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] start_step;
  logic [31:0] step_increment;
  logic [31:0] stop_step;
  logic [15:0] settle_samples;
  logic [15:0] dwell_samples;
  logic [16:0] data;
  logic        data_valid;
  logic [31:0] phase_step;
  logic        busy;
  logic [31:0] result_step;
  logic [16:0] result_peak;
  logic        result_valid;
  logic        result_ready;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sweep_peak_analyzer #(
    .PHASE_STEP_WIDTH(32),
    .DATA_WIDTH(17),
    .COUNT_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .start_step(start_step),
    .step_increment(step_increment),
    .stop_step(stop_step),
    .settle_samples(settle_samples),
    .dwell_samples(dwell_samples),
    .data(data),
    .data_valid(data_valid),
    .phase_step(phase_step),
    .busy(busy),
    .result_step(result_step),
    .result_peak(result_peak),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic begin_sweep(input logic [31:0] ss, input logic [31:0] inc, input logic [31:0] stp,
                             input logic [15:0] st, input logic [15:0] dw);
    @(negedge clock);
    start_step     = ss;
    step_increment = inc;
    stop_step      = stp;
    settle_samples = st;
    dwell_samples  = dw;
    start          = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic watch(input int n, output int dn, output int rv);
    dn = 0;
    rv = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (done) dn++;
      if (result_valid) rv++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; data = '0; data_valid = 1'b0; result_ready = 1'b0;
    start_step = '0; step_increment = '0; stop_step = '0; settle_samples = '0; dwell_samples = '0;
    #1;
    total_cnt++;
    if ({phase_step, busy, result_step, result_peak, result_valid, done} !== '0)
      $display("FAIL reset_outputs: got step=%h busy=%b rstep=%h peak=%h rv=%b done=%b, required all 0",
               phase_step, busy, result_step, result_peak, result_valid, done);
    else pass_cnt++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic_sweep();
    bit ok;
    int dn, rv;
    logic [31:0] exp_step;
    data = 17'd1000; data_valid = 1'b1; result_ready = 1'b1;
    begin_sweep(32'h000FFFFF, 32'h00100000, 32'h004FFFFF, 16'd4, 16'd8);
    for (int k = 0; k < 5; k++) begin
      exp_step = 32'h000FFFFF + 32'h00100000 * k;
      wait_result(ok);
      total_cnt++;
      if (!ok) $display("FAIL basic_step%0d: got no result, required step %h", k, exp_step);
      else if (result_step !== exp_step)
        $display("FAIL basic_step%0d: got %h required %h", k, result_step, exp_step);
      else pass_cnt++;
      total_cnt++;
      if (result_peak !== 17'd1000) $display("FAIL basic_peak%0d: got %0d required 1000", k, result_peak);
      else pass_cnt++;
    end
    watch(10, dn, rv);
    total_cnt++;
    if (dn !== 1 || rv !== 0) $display("FAIL basic_end: got done=%0d extra_results=%0d required 1 and 0", dn, rv);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_peak_pattern(input string name, input logic [16:0] a, input logic [16:0] b,
                                   input logic [16:0] c, input logic [15:0] dw, input logic [16:0] exp_peak);
    bit ok;
    int dn, rv;
    data = a; data_valid = 1'b1; result_ready = 1'b1;
    begin_sweep(32'h00000100, 32'h00000001, 32'h00000100, 16'd0, dw);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      case (n % 3)
        0:       data = a;
        1:       data = b;
        default: data = c;
      endcase
      @(negedge clock);
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!ok) $display("FAIL peak_%s: got no result, required peak %h", name, exp_peak);
    else if (result_peak !== exp_peak || result_step !== 32'h100)
      $display("FAIL peak_%s: got peak %h step %h required peak %h step 00000100", name, result_peak, result_step, exp_peak);
    else pass_cnt++;
    watch(5, dn, rv);
    total_cnt++;
    if (dn !== 1 || rv !== 0) $display("FAIL peak_%s_end: got done=%0d extra_results=%0d required 1 and 0", name, dn, rv);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    bit ok;
    int dn, rv;
    data = 17'd7; data_valid = 1'b1; result_ready = 1'b1;
    begin_sweep(32'hFFE00000, 32'h00100000, 32'hFFFFFFFF, 16'd1, 16'd2);
    wait_result(ok);
    total_cnt++;
    if (!ok || result_step !== 32'hFFE00000) $display("FAIL carry_first: got ok=%b step %h required FFE00000", ok, result_step);
    else pass_cnt++;
    wait_result(ok);
    total_cnt++;
    if (!ok || result_step !== 32'hFFF00000) $display("FAIL carry_second: got ok=%b step %h required FFF00000", ok, result_step);
    else pass_cnt++;
    watch(10, dn, rv);
    total_cnt++;
    if (dn !== 1 || rv !== 0) $display("FAIL carry_end: got done=%0d extra_results=%0d required 1 and 0", dn, rv);
    else pass_cnt++;
  endtask

  task automatic test_inverted_range();
    bit ok;
    int dn, rv;
    data = 17'd9; data_valid = 1'b1; result_ready = 1'b1;
    begin_sweep(32'h00000500, 32'h00000010, 32'h00000100, 16'd2, 16'd2);
    wait_result(ok);
    total_cnt++;
    if (!ok || result_step !== 32'h500) $display("FAIL inverted_step: got ok=%b step %h required 00000500", ok, result_step);
    else pass_cnt++;
    watch(10, dn, rv);
    total_cnt++;
    if (dn !== 1 || rv !== 0) $display("FAIL inverted_end: got done=%0d extra_results=%0d required 1 and 0", dn, rv);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit held;
    int dn, rv;
    data = 17'd300; data_valid = 1'b1; result_ready = 1'b0;
    begin_sweep(32'h00000010, 32'h00000010, 32'h00000020, 16'd2, 16'd3);
    wait_result(ok);
    total_cnt++;
    if (!ok || result_step !== 32'h10 || result_peak !== 17'd300)
      $display("FAIL bp_first: got ok=%b step %h peak %0d required 00000010 and 300", ok, result_step, result_peak);
    else pass_cnt++;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data = i[0] ? 17'd5000 : 17'h1E890;
      @(negedge clock);
      if (result_valid !== 1'b1 || result_step !== 32'h10 || result_peak !== 17'd300 || phase_step !== 32'h10)
        held = 1'b0;
    end
    total_cnt++;
    if (!held) $display("FAIL bp_hold: got rv=%b step %h peak %0d phase %h required 1, 00000010, 300, 00000010",
                        result_valid, result_step, result_peak, phase_step);
    else pass_cnt++;
    data = 17'd300;
    result_ready = 1'b1;
    wait_result(ok);
    total_cnt++;
    if (!ok || result_step !== 32'h20 || result_peak !== 17'd300)
      $display("FAIL bp_second: got ok=%b step %h peak %0d required 00000020 and 300", ok, result_step, result_peak);
    else pass_cnt++;
    watch(10, dn, rv);
    total_cnt++;
    if (dn !== 1 || rv !== 0) $display("FAIL bp_end: got done=%0d extra_results=%0d required 1 and 0", dn, rv);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit ok;
    int dn, rv;
    logic [31:0] exp_step;
    data = 17'd50; data_valid = 1'b1; result_ready = 1'b1;
    begin_sweep(32'h00000100, 32'h00000100, 32'h00000300, 16'd2, 16'd10);
    repeat (6) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_idle: got busy=%b rv=%b done=%b required 0 0 0", busy, result_valid, done);
    else pass_cnt++;
    watch(20, dn, rv);
    total_cnt++;
    if (dn !== 0 || rv !== 0) $display("FAIL abort_quiet: got done=%0d results=%0d required 0 and 0", dn, rv);
    else pass_cnt++;
    begin_sweep(32'h00000100, 32'h00000100, 32'h00000300, 16'd2, 16'd10);
    for (int k = 0; k < 3; k++) begin
      exp_step = 32'h100 * (k + 1);
      wait_result(ok);
      total_cnt++;
      if (!ok || result_step !== exp_step || result_peak !== 17'd50)
        $display("FAIL abort_rerun%0d: got ok=%b step %h peak %0d required %h and 50", k, ok, result_step, result_peak, exp_step);
      else pass_cnt++;
    end
    watch(10, dn, rv);
    total_cnt++;
    if (dn !== 1 || rv !== 0) $display("FAIL abort_rerun_end: got done=%0d extra_results=%0d required 1 and 0", dn, rv);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bit ok;
    int dn, rv;
    data = 17'd77; data_valid = 1'b1; result_ready = 1'b0;
    begin_sweep(32'h00000080, 32'h00000080, 32'h00000200, 16'd1, 16'd2);
    wait_result(ok);
    total_cnt++;
    if (!ok) $display("FAIL areset_setup: got no result, required REPORT before reset");
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({phase_step, busy, result_step, result_peak, result_valid, done} !== '0)
      $display("FAIL areset_outputs: got step=%h busy=%b rstep=%h peak=%h rv=%b done=%b, required all 0",
               phase_step, busy, result_step, result_peak, result_valid, done);
    else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    result_ready = 1'b1;
    begin_sweep(32'h00000040, 32'h00000040, 32'h00000040, 16'd0, 16'd1);
    total_cnt++;
    if (phase_step !== 32'h40 || busy !== 1'b1)
      $display("FAIL areset_restart: got phase %h busy %b required 00000040 and 1", phase_step, busy);
    else pass_cnt++;
    wait_result(ok);
    total_cnt++;
    if (!ok || result_step !== 32'h40 || result_peak !== 17'd77)
      $display("FAIL areset_result: got ok=%b step %h peak %0d required 00000040 and 77", ok, result_step, result_peak);
    else pass_cnt++;
    watch(5, dn, rv);
    total_cnt++;
    if (dn !== 1 || rv !== 0) $display("FAIL areset_end: got done=%0d extra_results=%0d required 1 and 0", dn, rv);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_peak_pattern("neg_full_scale", 17'd100, 17'h10000, 17'd200, 16'd8, 17'h10000);
    test_peak_pattern("mixed_sign", 17'h1FFFB, 17'd3, 17'h1FFF9, 16'd6, 17'd7);
    test_peak_pattern("pos_max", 17'h0FFFF, 17'h1FFFD, 17'd12, 16'd4, 17'h0FFFF);
    test_peak_pattern("dwell_zero", 17'd42, 17'd42, 17'd42, 16'd0, 17'd42);
    test_carry();
    test_inverted_range();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
